// File: rtl/nios_project_keys_in.sv
// nios_project_keys_in
// Avalon-MM input port for board push-buttons / switches. Each raw input is
// synchronised, debounced, and edge-detected. Selected edges are latched in a
// sticky capture register, which software clears with write-1-to-clear. A
// per-bit mask gates the captured edges onto a level interrupt.
module nios_project_keys_in #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
    logic [31:0]      readdata_q, readdata_d;

    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] w1c;
    logic             wr_en;

    // Per-bit debounce counter. A bit is accepted once the synchronised value
    // has disagreed with the stable value for DEBOUNCE_CYCLES consecutive edges.
    // Any return to agreement restarts the count, so short glitches never
    // reach the stable value.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_debounce
        logic [CW-1:0] cnt_q, cnt_d;
        logic          differs;

        assign differs    = (sync2_q[gi] != stable_q[gi]);
        assign accept[gi] = differs && (cnt_q == CNT_LAST);

        // Next count: clear on agreement or on accept, otherwise count up.
        always_comb begin
            cnt_d = '0;
            if (differs && !accept[gi]) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // Counter register.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    assign wr_en = chipselect && !write_n;

    // Next-state for the synchroniser, the stable value, edge capture, mask and readback.
    always_comb begin
        sync1_d        = in_port;
        sync2_d        = sync1_q;
        stable_d       = stable_q ^ accept;
        irq_mask_d     = irq_mask_q;
        edge_capture_d = edge_capture_q;
        readdata_d     = '0;
        edge_set       = '0;
        w1c            = '0;

        // Only edges produced by an accepted change are seen here.
        case (EDGE_TYPE)
            0:       edge_set = accept & stable_d;
            1:       edge_set = accept & ~stable_d;
            default: edge_set = accept;
        endcase

        if (wr_en && address == ADDR_IRQMASK) begin
            irq_mask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && address == ADDR_EDGECAP) begin
            w1c = writedata[WIDTH-1:0];
        end

        // The clear is applied before the set, so a new edge wins over a simultaneous clear.
        edge_capture_d = (edge_capture_q & ~w1c) | edge_set;

        case (address)
            ADDR_DATA:    readdata_d[WIDTH-1:0] = stable_q;
            ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irq_mask_q;
            ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edge_capture_q;
            default:      readdata_d = '0;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q        <= '0;
            sync2_q        <= '0;
            stable_q       <= '0;
            irq_mask_q     <= '0;
            edge_capture_q <= '0;
            readdata_q     <= '0;
        end else begin
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            stable_q       <= stable_d;
            irq_mask_q     <= irq_mask_d;
            edge_capture_q <= edge_capture_d;
            readdata_q     <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edge_capture_q & irq_mask_q);

endmodule

// File: tb/tb_nios_project_keys_in.sv
// Directed bench for nios_project_keys_in with WIDTH=4, DEBOUNCE_CYCLES=4,
// EDGE_TYPE=1. Inputs change 1 time unit after a rising edge, and outputs are
// sampled at the same point. Read data therefore reflects the register state
// before the edge that was just taken.
module tb_nios_project_keys_in;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [3:0]  in_port = 4'hF;
    logic [31:0] readdata;
    logic        irq;

    int compared = 0;
    int mismatched = 0;
    logic [31:0] rd;

    nios_project_keys_in #(
        .WIDTH(4),
        .DEBOUNCE_CYCLES(4),
        .EDGE_TYPE(1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .in_port(in_port),
        .readdata(readdata),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s observed %h expected %h", tag, obs, exp);
        end
        $display("check %-16s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a;
        writedata = d;
        chipselect = 1'b1;
        write_n = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n = 1'b1;
        writedata = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address = a;
        chipselect = 1'b1;
        write_n = 1'b1;
        tick(1);
        d = readdata;
        chipselect = 1'b0;
    endtask

    initial begin
        // 1: reset with all keys released (high)
        tick(3);
        check("rst_readdata", readdata, 32'h0);
        check("rst_irq", {31'd0, irq}, 32'h0);
        reset_n = 1'b1;                 // released 1 unit after an edge
        address = 2'd0;
        tick(6);                        // in_port sampled at first edge t0; stable rises at t0+5
        check("data_lat_before", readdata, 32'h0);
        tick(1);
        check("data_lat_after", readdata, 32'h0000000F);
        bus_read(2'd3, rd);
        check("rst_edgecap", rd, 32'h0);   // rising edge not captured for falling mode

        // 2: glitch of 3 cycles on bit0 is rejected
        in_port = 4'hE;
        tick(3);
        in_port = 4'hF;
        tick(8);
        bus_read(2'd0, rd);
        check("glitch_data", rd, 32'h0000000F);
        bus_read(2'd3, rd);
        check("glitch_edgecap", rd, 32'h0);

        // 3: mask bit0, then a held falling edge on bit0
        bus_write(2'd2, 32'h1);
        in_port = 4'hE;
        tick(5);                        // edges t0..t0+4
        check("irq_before_acc", {31'd0, irq}, 32'h0);
        tick(1);                        // edge t0+5: stable falls, capture set
        check("irq_on_accept", {31'd0, irq}, 32'h1);
        bus_read(2'd3, rd);
        check("edgecap_bit0", rd, 32'h1);
        bus_read(2'd0, rd);
        check("data_E", rd, 32'h0000000E);

        // 4: W1C clears; writing 0 leaves a pending bit alone; DATA is read-only
        bus_write(2'd3, 32'h1);
        check("irq_cleared", {31'd0, irq}, 32'h0);
        bus_read(2'd3, rd);
        check("edgecap_clr", rd, 32'h0);
        in_port = 4'hA;                 // bit2 falls
        tick(10);
        bus_write(2'd3, 32'h0);
        bus_read(2'd3, rd);
        check("w0_keeps", rd, 32'h4);
        check("irq_masked_b2", {31'd0, irq}, 32'h0);
        bus_write(2'd3, 32'h4);
        bus_read(2'd3, rd);
        check("edgecap_clr_b2", rd, 32'h0);
        bus_write(2'd0, 32'h0);
        bus_read(2'd0, rd);
        check("data_ro", rd, 32'h0000000A);

        // 5: W1C on bit1 on the same edge its falling edge is accepted
        in_port = 4'h8;
        tick(5);                        // edges t0..t0+4
        bus_write(2'd3, 32'h2);         // lands on t0+5
        bus_read(2'd3, rd);
        check("set_wins", rd, 32'h2);
        bus_read(2'd0, rd);
        check("data_8", rd, 32'h00000008);

        // 6: pending bit1 with mask bit0 only; enabling the mask raises irq
        bus_write(2'd2, 32'h0);
        check("irq_mask0", {31'd0, irq}, 32'h0);
        bus_write(2'd2, 32'h2);
        check("irq_mask2", {31'd0, irq}, 32'h1);
        bus_read(2'd1, rd);
        check("reserved", rd, 32'h0);
        bus_read(2'd2, rd);
        check("irqmask_rd", rd, 32'h2);
        bus_write(2'd2, 32'hFFFF_FFF0);  // bits above WIDTH are ignored
        check("irq_unmask", {31'd0, irq}, 32'h0);
        bus_read(2'd3, rd);
        check("edge_kept", rd, 32'h2);
        bus_read(2'd2, rd);
        check("mask_upper0", rd, 32'h0);

        // Asynchronous reset while irq is high
        bus_write(2'd2, 32'h2);
        check("irq_pre_rst", {31'd0, irq}, 32'h1);
        reset_n = 1'b0;
        #1;
        check("async_irq", {31'd0, irq}, 32'h0);
        check("async_rdata", readdata, 32'h0);
        tick(2);
        reset_n = 1'b1;
        in_port = 4'hF;
        tick(12);
        bus_read(2'd0, rd);
        check("post_rst_data", rd, 32'h0000000F);
        bus_read(2'd3, rd);
        check("post_rst_cap", rd, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
